// File: rtl/rvh_l1d_refill_buf.sv
// Per-bank D$ refill collector: assembles L2 R-channel bursts into one line buffer
// per MSHR entry, offers completed lines to the RAM refill port, then frees the entry.
module rvh_l1d_refill_buf #(
    parameter int N_MSHR     = 4,
    parameter int N_MSHR_W   = $clog2(N_MSHR),
    parameter int BURST_SIZE = 4,
    parameter int BEAT_W     = 64,
    parameter int LINE_W     = BURST_SIZE * BEAT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                l2_resp_if_rvalid,
    output logic                l2_resp_if_rready,
    input  logic [N_MSHR_W-1:0] l2_resp_if_rid,
    input  logic [BEAT_W-1:0]   l2_resp_if_rdata,
    input  logic [1:0]          l2_resp_if_rresp,
    input  logic                l2_resp_if_rlast,
    input  logic [N_MSHR-1:0]   mshr_bank_no_resp_i,
    output logic                refill_valid_o,
    input  logic                refill_ready_i,
    output logic [N_MSHR_W-1:0] refill_mshr_id_o,
    output logic [LINE_W-1:0]   refill_data_o,
    output logic                refill_err_o,
    output logic                refill_no_resp_o,
    output logic                mlfb_mshr_dealloc_valid_o,
    output logic [N_MSHR_W-1:0] mlfb_mshr_dealloc_idx_o,
    input  logic                mlfb_mshr_dealloc_ready_i
);

    localparam int CNT_W = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_REFILL, S_DEALLOC} state_e;

    state_e           state_q [N_MSHR];
    state_e           state_d [N_MSHR];
    logic [CNT_W-1:0] cnt_q   [N_MSHR];
    logic [CNT_W-1:0] cnt_d   [N_MSHR];
    logic             err_q   [N_MSHR];
    logic             err_d   [N_MSHR];
    logic [LINE_W-1:0] line_q [N_MSHR];

    state_e           rid_state;
    logic             rid_open;
    logic             beat_acc;
    logic             beat_ovr;
    logic             beat_err;
    logic [CNT_W-1:0] beat_cnt;

    logic                ref_found;
    logic [N_MSHR_W-1:0] ref_idx;
    logic                dea_found;
    logic [N_MSHR_W-1:0] dea_idx;
    logic                refill_fire;
    logic                dealloc_fire;

    // Decode of the entry addressed by the incoming beat; an IDLE entry restarts at slot 0 with err clear.
    always_comb begin
        rid_state = state_q[l2_resp_if_rid];
        rid_open  = (rid_state == S_IDLE) || (rid_state == S_FILL);
        beat_acc  = l2_resp_if_rvalid && rid_open && !rst;
        beat_cnt  = (rid_state == S_IDLE) ? '0 : cnt_q[l2_resp_if_rid];
        beat_ovr  = !l2_resp_if_rlast && (beat_cnt == CNT_MAX);
        beat_err  = ((rid_state == S_FILL) && err_q[l2_resp_if_rid])
                  || (l2_resp_if_rresp != 2'b00)
                  || beat_ovr
                  || (l2_resp_if_rlast && (beat_cnt != CNT_MAX));
    end

    always_comb begin
        ref_found = 1'b0;
        ref_idx   = '0;
        dea_found = 1'b0;
        dea_idx   = '0;
        for (int unsigned i = 0; i < N_MSHR; i++) begin
            if (!ref_found && state_q[i] == S_REFILL) begin
                ref_found = 1'b1;
                ref_idx   = N_MSHR_W'(i);
            end
            if (!dea_found && state_q[i] == S_DEALLOC) begin
                dea_found = 1'b1;
                dea_idx   = N_MSHR_W'(i);
            end
        end
    end

    assign l2_resp_if_rready         = rst || rid_open;
    assign refill_valid_o            = ref_found && !rst;
    assign refill_mshr_id_o          = rst ? '0 : ref_idx;
    assign refill_data_o             = line_q[ref_idx];
    assign refill_err_o              = refill_valid_o && err_q[ref_idx];
    assign refill_no_resp_o          = mshr_bank_no_resp_i[refill_mshr_id_o];
    assign mlfb_mshr_dealloc_valid_o = dea_found && !rst;
    assign mlfb_mshr_dealloc_idx_o   = rst ? '0 : dea_idx;
    assign refill_fire               = refill_valid_o && refill_ready_i;
    assign dealloc_fire              = mlfb_mshr_dealloc_valid_o && mlfb_mshr_dealloc_ready_i;

    always_comb begin
        for (int unsigned i = 0; i < N_MSHR; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            err_d[i]   = err_q[i];
            if (beat_acc && l2_resp_if_rid == N_MSHR_W'(i)) begin
                err_d[i] = beat_err;
                if (l2_resp_if_rlast) begin
                    state_d[i] = S_REFILL;
                    cnt_d[i]   = beat_cnt;
                end else begin
                    state_d[i] = S_FILL;
                    cnt_d[i]   = beat_ovr ? beat_cnt : beat_cnt + 1'b1;
                end
            end
            if (refill_fire && ref_idx == N_MSHR_W'(i)) begin
                state_d[i] = S_DEALLOC;
            end
            if (dealloc_fire && dea_idx == N_MSHR_W'(i)) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_MSHR; i++) begin
            if (rst) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                err_q[i]   <= 1'b0;
            end else begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                err_q[i]   <= err_d[i];
            end
        end
    end

    // Line storage is not reset; overrun beats are dropped so the last slot keeps the rlast beat.
    always_ff @(posedge clk) begin
        if (beat_acc && !beat_ovr) begin
            line_q[l2_resp_if_rid][int'(beat_cnt)*BEAT_W +: BEAT_W] <= l2_resp_if_rdata;
        end
    end

endmodule
